alu_share_ctrl: RTL and testbench

- Round-robin controller that time-shares one combinational 64-bit ALU between NREQ requesters.
- Each requester issues an operation through a valid/ready request channel. The controller registers the operands, drives the shared ALU for one cycle, captures the result and zero flag, and returns them on a per-requester valid/ready response channel.
- Sits between the ALU and its client units (e.g. the execute stage and the address-generation unit).

---
 rtl/alu_share_ctrl.sv | 160 ++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin controller that time-shares one combinational ALU among NREQ
// requesters: registered operands, one-cycle execute, held per-requester response.
module alu_share_ctrl #(
  parameter int NREQ = 4,
  parameter int W    = 64,
  parameter int IW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_in1,
  input  logic [NREQ*W-1:0] req_in2,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      resp_result,
  output logic              resp_zero,
  output logic              resp_err,
  output logic [IW-1:0]     resp_id,
  output logic [W-1:0]      alu_in1,
  output logic [W-1:0]      alu_in2,
  output logic [3:0]        alu_c,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_id;
  logic [W-1:0]  r_alu_in1;
  logic [W-1:0]  r_alu_in2;
  logic [3:0]    r_alu_c;
  logic [W-1:0]  r_result;
  logic          r_zero;
  logic          r_err;

  logic [IW-1:0] w_grant;
  logic [IW-1:0] w_cand;
  logic          w_found;
  logic          w_hit;
  int            w_idx;
  logic          w_hs;
  logic          w_done;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0010, 4'b0110, 4'b0000, 4'b0001: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    if (id == IW'(NREQ - 1)) next_id = {IW{1'b0}};
    else                     next_id = id + IW'(1);
  endfunction

  // Round-robin scan starting at r_ptr; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = {IW{1'b0}};
    w_idx   = 0;
    w_cand  = {IW{1'b0}};
    w_hit   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx   = (int'(r_ptr) + k) % NREQ;
      w_cand  = IW'(w_idx);
      w_hit   = req_valid[w_cand] & ~w_found;
      w_grant = w_hit ? w_cand : w_grant;
      w_found = w_found | req_valid[w_cand];
    end
  end

  assign w_hs   = (r_state == S_IDLE) && w_found;
  assign w_done = (r_state == S_RESP) && resp_ready[r_id];

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_found ? S_EXEC : S_IDLE;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  w_next = w_done ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake decode: ready only in IDLE, response valid only in RESP.
  always_comb begin
    req_ready  = {NREQ{1'b0}};
    resp_valid = {NREQ{1'b0}};
    if (r_state == S_IDLE && w_found) begin
      req_ready[w_grant] = 1'b1;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
    if (r_state == S_RESP) begin
      resp_valid[r_id] = 1'b1;
    end else begin
      resp_valid = {NREQ{1'b0}};
    end
  end

  // State register and rotation pointer; the pointer moves only on response completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= {IW{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_done) r_ptr <= next_id(r_id);
    end
  end

  // Operand capture at handshake, result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_in1 <= {W{1'b0}};
      r_alu_in2 <= {W{1'b0}};
      r_alu_c   <= 4'b0000;
      r_id      <= {IW{1'b0}};
      r_result  <= {W{1'b0}};
      r_zero    <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_hs) begin
      r_alu_in1 <= req_in1[w_grant*W +: W];
      r_alu_in2 <= req_in2[w_grant*W +: W];
      r_alu_c   <= req_op[w_grant*4 +: 4];
      r_id      <= w_grant;
    end else if (r_state == S_EXEC) begin
      if (op_legal(r_alu_c)) begin
        r_result <= alu_result;
        r_zero   <= alu_zero;
        r_err    <= 1'b0;
      end else begin
        r_result <= {W{1'b0}};
        r_zero   <= 1'b1;
        r_err    <= 1'b1;
      end
    end
  end

  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign alu_c       = r_alu_c;
  assign resp_result = r_result;
  assign resp_zero   = r_zero;
  assign resp_err    = r_err;
  assign resp_id     = r_id;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: a behavioural ALU, a negedge monitor
// that models grant order and expected results, and directed request scenarios.
module tb_alu_share_ctrl;
  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_in1;
  logic [NREQ*W-1:0] req_in2;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [W-1:0]      resp_result;
  logic              resp_zero;
  logic              resp_err;
  logic [IW-1:0]     resp_id;
  logic [W-1:0]      alu_in1;
  logic [W-1:0]      alu_in2;
  logic [3:0]        alu_c;
  logic [W-1:0]      alu_result;
  logic              alu_zero;
  logic              busy;

  alu_share_ctrl #(.NREQ(NREQ), .W(W), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .resp_id(resp_id),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_c(alu_c),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; illegal codes return a nonzero junk value the DUT must ignore.
  always_comb begin
    case (alu_c)
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0110: alu_result = alu_in1 - alu_in2;
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      default: alu_result = 64'hDEAD_BEEF_0000_0001;
    endcase
  end
  assign alu_zero = (alu_result == 64'd0);

  typedef struct {
    int         id;
    logic [W-1:0] res;
    logic       z;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   gcyc[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   exp_ptr  = 0;
  bit   mdl_busy = 1'b0;
  bit   prev_rv  = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] op, input int c);
    exp_t e;
    e.id  = id;
    e.cyc = c;
    e.e   = 1'b0;
    case (op)
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      default: begin e.res = 64'd0; e.e = 1'b1; end
    endcase
    e.z = (e.res == 64'd0);
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: grant model, busy model, scoreboard push on handshake, pop on response.
  always @(negedge clk) begin : mon
    logic [NREQ-1:0] er;
    int g;
    int idx;
    if (!rst_n) begin
      sb.delete();
      mdl_busy = 1'b0;
      exp_ptr  = 0;
      prev_rv  = 1'b0;
    end else begin
      er = '0;
      g  = -1;
      if (!mdl_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (exp_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) er[g] = 1'b1;
      check_val("req_ready", req_ready, er);
      check_val("busy", busy, mdl_busy);
      if (g >= 0) begin
        sb.push_back(model(g, req_in1[g*W +: W], req_in2[g*W +: W], req_op[g*4 +: 4], cyc));
        glog.push_back(g);
        gcyc.push_back(cyc);
        mdl_busy = 1'b1;
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          check_val("resp_unexpected", resp_valid, 64'd0);
        end else begin
          if (!prev_rv) check_val("latency", cyc - sb[0].cyc, 64'd2);
          if (resp_ready[sb[0].id]) begin
            check_val("resp_valid", resp_valid, 64'd1 << sb[0].id);
            check_val("resp_id", resp_id, sb[0].id);
            check_val("resp_result", resp_result, sb[0].res);
            check_val("resp_zero", resp_zero, sb[0].z);
            check_val("resp_err", resp_err, sb[0].e);
            exp_ptr  = (sb[0].id + 1) % NREQ;
            mdl_busy = 1'b0;
            void'(sb.pop_front());
          end
        end
      end
      prev_rv = (resp_valid != '0);
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op);
    req_in1[i*W +: W] = a;
    req_in2[i*W +: W] = b;
    req_op[i*4 +: 4]  = op;
    req_valid[i]      = 1'b1;
  endtask

  // Single request: wait for its grant, drop valid, then scramble operands.
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] op);
    bit hs;
    hs = 1'b0;
    @(posedge clk); #1;
    set_req(i, a, b, op);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin hs = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid[i]      = 1'b0;
    req_in1[i*W +: W] = ~a;
    req_in2[i*W +: W] = ~b;
    req_op[i*4 +: 4]  = 4'b0110;
    if (!hs) check_val("hs_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    check_val("drain", sb.size(), 64'd0);
  endtask

  task automatic wait_grants(input int n);
    for (int k = 0; k < 300; k++) begin
      if (glog.size() >= n) break;
      @(posedge clk); #1;
    end
    check_val("grant_count", glog.size() >= n, 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held;
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '1;
    req_in1    = '0;
    req_in2    = '0;
    req_op     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_alu_in1", alu_in1, 64'd0);
    check_val("rst_alu_c", alu_c, 64'd0);
    check_val("rst_result", resp_result, 64'd0);
    check_val("rst_zero", resp_zero, 64'd0);
    check_val("rst_err", resp_err, 64'd0);
    check_val("rst_id", resp_id, 64'd0);
    check_val("rst_resp_valid", resp_valid, 64'd0);
    check_val("rst_busy", busy, 64'd0);
    rst_n = 1'b1;

    // Basic add, then subtract to zero and subtract wrap-around.
    issue(0, 64'd5, 64'd7, 4'b0010);
    wait_idle();
    issue(2, 64'd9, 64'd9, 4'b0110);
    wait_idle();
    issue(2, 64'd0, 64'd1, 4'b0110);
    wait_idle();
    check_val("wrap_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFF);

    // All four requesters held valid: rotation 0,1,2,3,0 at 3-cycle spacing.
    do_reset();
    glog.delete();
    gcyc.delete();
    @(posedge clk); #1;
    set_req(0, 64'hF0F0, 64'hFF00, 4'b0000);
    set_req(1, 64'h0F, 64'hF0, 4'b0001);
    set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'b0010);
    set_req(3, 64'd3, 64'd5, 4'b0110);
    wait_grants(5);
    req_valid = '0;
    wait_idle();
    check_val("rr_grants", glog.size(), 64'd5);
    for (int k = 0; k < 5 && k < glog.size(); k++) begin
      check_val("rr_order", glog[k], k % NREQ);
      if (k > 0) check_val("rr_spacing", gcyc[k] - gcyc[k-1], 64'd3);
    end

    // Illegal opcode, then a legal one from the same requester.
    issue(1, 64'hFF, 64'h0F, 4'b0101);
    wait_idle();
    issue(1, 64'hF0, 64'h0F, 4'b0001);
    wait_idle();

    // Response back-pressure on requester 3 while requester 1 waits.
    do_reset();
    glog.delete();
    resp_ready = 4'b0111;
    issue(3, 64'd100, 64'd1, 4'b0110);
    set_req(1, 64'd3, 64'd4, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    held = resp_result;
    check_val("bp_result", held, 64'd99);
    for (int n = 0; n < 10; n++) begin
      check_val("bp_resp_valid", resp_valid, 64'b1000);
      check_val("bp_req_ready", req_ready, 64'd0);
      check_val("bp_stable", resp_result, held);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = '1;
    wait_grants(2);
    req_valid = '0;
    wait_idle();
    if (glog.size() >= 2) check_val("bp_next_grant", glog[1], 64'd1);

    // Reset while executing: immediate clear, no response, rotation restarts at 0.
    do_reset();
    issue(2, 64'd1, 64'd2, 4'b0010);
    rst_n = 1'b0;
    #1;
    check_val("mid_busy", busy, 64'd0);
    check_val("mid_resp_valid", resp_valid, 64'd0);
    check_val("mid_alu_in1", alu_in1, 64'd0);
    check_val("mid_result", resp_result, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_val("abort_no_resp", resp_valid, 64'd0);
    end
    glog.delete();
    @(posedge clk); #1;
    set_req(3, 64'd10, 64'd20, 4'b0000);
    set_req(0, 64'd6, 64'd6, 4'b0110);
    wait_grants(1);
    req_valid[0] = 1'b0;
    wait_grants(2);
    req_valid[3] = 1'b0;
    wait_idle();
    if (glog.size() >= 2) begin
      check_val("post_rst_first", glog[0], 64'd0);
      check_val("post_rst_second", glog[1], 64'd3);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
